// File: rtl/engine_csr_index_config_assembler_if.sv
// Handshake bundle between the CU setup response stream, the config assembler and the CSR index generator.
interface engine_csr_index_config_assembler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int META_W = 32
);
    logic                    start_in;
    logic                    resp_in_valid;
    logic [DATA_W-1:0]       resp_in_data;
    logic [META_W-1:0]       resp_in_meta;
    logic                    resp_in_ready;
    logic                    config_out_valid;
    logic                    config_out_ready;
    logic [4+6*ADDR_W-1:0]   config_out_param;
    logic [META_W-1:0]       config_out_meta;
    logic                    config_error;
    logic                    done_out;

    modport master (
        output start_in, resp_in_valid, resp_in_data, resp_in_meta, config_out_ready,
        input  resp_in_ready, config_out_valid, config_out_param, config_out_meta,
               config_error, done_out
    );

    modport slave (
        input  start_in, resp_in_valid, resp_in_data, resp_in_meta, config_out_ready,
        output resp_in_ready, config_out_valid, config_out_param, config_out_meta,
               config_error, done_out
    );
endinterface

// File: rtl/engine_csr_index_config_assembler.sv
// Deserialises seven 32-bit setup response words into one CSR index configuration; valid rises after
// a one-cycle check state following word 6, and the config is held until config_out_ready.
module engine_csr_index_config_assembler #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int META_W = 32
) (
    input  logic                                  ap_clk,
    input  logic                                  areset,
    engine_csr_index_config_assembler_if.slave    bus
);

    typedef enum logic [2:0] {
        CFG_RESET   = 3'd0,
        CFG_IDLE    = 3'd1,
        CFG_COLLECT = 3'd2,
        CFG_CHECK   = 3'd3,
        CFG_HOLD    = 3'd4,
        CFG_DONE    = 3'd5
    } cfg_state_t;

    cfg_state_t          state;
    cfg_state_t          state_next;
    logic [2:0]          word_cnt;

    logic                increment;
    logic                decrement;
    logic                mode_sequence;
    logic                mode_buffer;
    logic [ADDR_W-1:0]   array_pointer;
    logic [ADDR_W-1:0]   array_size;
    logic [ADDR_W-1:0]   index_start;
    logic [ADDR_W-1:0]   index_end;
    logic [ADDR_W-1:0]   stride;
    logic [ADDR_W-1:0]   granularity;
    logic [META_W-1:0]   meta;

    logic                resp_ready;
    logic                out_valid;
    logic                cfg_err;
    logic                done;
    logic                accept;
    logic                cfg_bad;

    // Flag bits above bit 3 and data bits above ADDR_W carry nothing for this block.
    logic                unused_data;
    assign unused_data = ^bus.resp_in_data;

    assign cfg_bad = (increment && decrement) || (granularity == '0) || (stride == '0);
    assign accept  = resp_ready && bus.resp_in_valid;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state <= CFG_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        resp_ready = 1'b0;
        out_valid  = 1'b0;
        cfg_err    = 1'b0;
        done       = 1'b0;
        case (state)
            CFG_RESET:   state_next = CFG_IDLE;
            CFG_IDLE: begin
                if (bus.start_in) begin
                    state_next = CFG_COLLECT;
                end
            end
            CFG_COLLECT: begin
                resp_ready = 1'b1;
                if (bus.resp_in_valid && (word_cnt == 3'd6)) begin
                    state_next = CFG_CHECK;
                end
            end
            CFG_CHECK: begin
                cfg_err    = cfg_bad;
                state_next = cfg_bad ? CFG_DONE : CFG_HOLD;
            end
            CFG_HOLD: begin
                out_valid = 1'b1;
                if (bus.config_out_ready) begin
                    state_next = CFG_DONE;
                end
            end
            CFG_DONE: begin
                done       = 1'b1;
                state_next = CFG_IDLE;
            end
            default:     state_next = CFG_RESET;
        endcase
    end

    // Fields are overwritten word by word, so the previous config stays visible until a new collect.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            word_cnt      <= 3'd0;
            increment     <= 1'b0;
            decrement     <= 1'b0;
            mode_sequence <= 1'b0;
            mode_buffer   <= 1'b0;
            array_pointer <= '0;
            array_size    <= '0;
            index_start   <= '0;
            index_end     <= '0;
            stride        <= '0;
            granularity   <= '0;
            meta          <= '0;
        end else begin
            if ((state == CFG_IDLE) && bus.start_in) begin
                word_cnt <= 3'd0;
            end else if (accept) begin
                word_cnt <= word_cnt + 3'd1;
            end
            if (accept) begin
                case (word_cnt)
                    3'd0: begin
                        increment     <= bus.resp_in_data[0];
                        decrement     <= bus.resp_in_data[1];
                        mode_sequence <= bus.resp_in_data[2];
                        mode_buffer   <= bus.resp_in_data[3];
                        meta          <= bus.resp_in_meta;
                    end
                    3'd1:    array_pointer <= bus.resp_in_data[ADDR_W-1:0];
                    3'd2:    array_size    <= bus.resp_in_data[ADDR_W-1:0];
                    3'd3:    index_start   <= bus.resp_in_data[ADDR_W-1:0];
                    3'd4:    index_end     <= bus.resp_in_data[ADDR_W-1:0];
                    3'd5:    stride        <= bus.resp_in_data[ADDR_W-1:0];
                    3'd6:    granularity   <= bus.resp_in_data[ADDR_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.resp_in_ready    = resp_ready;
    assign bus.config_out_valid = out_valid;
    assign bus.config_error     = cfg_err;
    assign bus.done_out         = done;
    assign bus.config_out_meta  = meta;
    assign bus.config_out_param = {increment, decrement, mode_sequence, mode_buffer,
                                   array_pointer, array_size, index_start, index_end,
                                   stride, granularity};

endmodule

// File: tb/tb_engine_csr_index_config_assembler.sv
// Scoreboard bench for the CSR index config assembler: expected configs are queued when words are driven.
module tb_engine_csr_index_config_assembler;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int META_W = 32;
    localparam int PW     = 4 + 6 * ADDR_W;

    typedef logic [DATA_W-1:0] words_t [7];

    typedef struct {
        logic [PW-1:0]     param;
        logic [META_W-1:0] meta;
        bit                err;
    } exp_t;

    logic ap_clk = 1'b0;
    logic areset;
    always #5 ap_clk = ~ap_clk;

    engine_csr_index_config_assembler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .META_W(META_W)) bus ();

    engine_csr_index_config_assembler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .META_W(META_W)) dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .bus    (bus)
    );

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic exp_t model(input words_t w, input logic [META_W-1:0] m);
        exp_t e;
        e.param = {w[0][0], w[0][1], w[0][2], w[0][3],
                   w[1][ADDR_W-1:0], w[2][ADDR_W-1:0], w[3][ADDR_W-1:0],
                   w[4][ADDR_W-1:0], w[5][ADDR_W-1:0], w[6][ADDR_W-1:0]};
        e.meta  = m;
        e.err   = (w[0][0] && w[0][1]) || (w[6][ADDR_W-1:0] == '0) || (w[5][ADDR_W-1:0] == '0);
        return e;
    endfunction

    // Pulses start, then presents nwords words; with gaps, every other cycle carries junk with valid low.
    task automatic feed(input words_t w, input logic [META_W-1:0] m, input bit gaps, input int nwords);
        int  i     = 0;
        int  cyc   = 0;
        bit  phase = 1'b0;
        bit  acc;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        while (i < nwords && cyc < 40) begin
            if (gaps && phase) begin
                bus.resp_in_valid = 1'b0;
                bus.resp_in_data  = 32'hDEAD_BEEF;
                bus.resp_in_meta  = ~m;
            end else begin
                bus.resp_in_valid = 1'b1;
                bus.resp_in_data  = w[i];
                bus.resp_in_meta  = (i == 0) ? m : ~m;
            end
            acc = bus.resp_in_valid && bus.resp_in_ready;
            tick();
            cyc++;
            phase = ~phase;
            if (acc) i++;
        end
        bus.resp_in_valid = 1'b0;
        bus.resp_in_data  = '0;
        bus.resp_in_meta  = '0;
        if (i < nwords) begin
            vectors++;
            miscompares++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", i, nwords);
        end
    endtask

    // Called in the cycle after the edge that accepted word 6 (the check cycle).
    task automatic finish_cfg(input string name, input int hold_cycles, input bit start_in_hold);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_sb_empty: no expected entry queued", name);
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (bus.config_out_valid !== 1'b0 || bus.config_error !== e.err) begin
            miscompares++;
            $display("FAIL %s_check: valid=%b err=%b, required valid=0 err=%b",
                     name, bus.config_out_valid, bus.config_error, e.err);
        end
        tick();
        if (e.err) begin
            vectors++;
            if (bus.done_out !== 1'b1 || bus.config_out_valid !== 1'b0 || bus.config_error !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_err_done: done=%b valid=%b err=%b, required 1 0 0",
                         name, bus.done_out, bus.config_out_valid, bus.config_error);
            end
            tick();
            vectors++;
            if (bus.done_out !== 1'b0 || bus.resp_in_ready !== 1'b0 || bus.config_out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_err_idle: done=%b ready=%b valid=%b, required 0 0 0",
                         name, bus.done_out, bus.resp_in_ready, bus.config_out_valid);
            end
            return;
        end
        vectors++;
        if (bus.config_out_valid !== 1'b1 || bus.config_out_param !== e.param || bus.config_out_meta !== e.meta) begin
            miscompares++;
            $display("FAIL %s_out: valid=%b param=%h meta=%h, required valid=1 param=%h meta=%h",
                     name, bus.config_out_valid, bus.config_out_param, bus.config_out_meta, e.param, e.meta);
        end
        if (hold_cycles > 0) bus.config_out_ready = 1'b0;
        for (int k = 0; k < hold_cycles; k++) begin
            if (start_in_hold) bus.start_in = 1'b1;
            tick();
            bus.start_in = 1'b0;
            vectors++;
            if (bus.config_out_valid !== 1'b1 || bus.config_out_param !== e.param || bus.done_out !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_hold%0d: valid=%b done=%b param=%h, required valid=1 done=0 param=%h",
                         name, k, bus.config_out_valid, bus.done_out, bus.config_out_param, e.param);
            end
        end
        bus.config_out_ready = 1'b1;
        tick();
        bus.config_out_ready = 1'b0;
        vectors++;
        if (bus.done_out !== 1'b1 || bus.config_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: done=%b valid=%b, required done=1 valid=0",
                     name, bus.done_out, bus.config_out_valid);
        end
        tick();
        vectors++;
        if (bus.done_out !== 1'b0 || bus.resp_in_ready !== 1'b0 || bus.config_out_param !== e.param
            || bus.config_out_meta !== e.meta) begin
            miscompares++;
            $display("FAIL %s_after: done=%b ready=%b param=%h meta=%h, required 0 0 param=%h meta=%h",
                     name, bus.done_out, bus.resp_in_ready, bus.config_out_param, bus.config_out_meta,
                     e.param, e.meta);
        end
    endtask

    task automatic run_cfg(input string name, input words_t w, input logic [META_W-1:0] m,
                           input bit gaps, input int hold_cycles, input bit start_in_hold);
        sb.push_back(model(w, m));
        feed(w, m, gaps, 7);
        finish_cfg(name, hold_cycles, start_in_hold);
    endtask

    words_t base_words;

    task automatic test_reset();
        areset                = 1'b1;
        bus.start_in          = 1'b0;
        bus.resp_in_valid     = 1'b0;
        bus.resp_in_data      = '0;
        bus.resp_in_meta      = '0;
        bus.config_out_ready  = 1'b0;
        repeat (3) tick();
        vectors++;
        if (bus.resp_in_ready !== 1'b0 || bus.config_out_valid !== 1'b0 || bus.config_error !== 1'b0
            || bus.done_out !== 1'b0 || bus.config_out_param !== '0 || bus.config_out_meta !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b vld=%b err=%b done=%b param=%h meta=%h, required all 0",
                     bus.resp_in_ready, bus.config_out_valid, bus.config_error, bus.done_out,
                     bus.config_out_param, bus.config_out_meta);
        end
        areset = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.resp_in_ready !== 1'b0 || bus.config_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: rdy=%b vld=%b, required 0 0", bus.resp_in_ready, bus.config_out_valid);
        end
    endtask

    task automatic test_basic();
        run_cfg("basic", base_words, 32'hA5A5_0001, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_cfg("backpressure", base_words, 32'h0000_BEEF, 1'b0, 5, 1'b0);
    endtask

    task automatic test_valid_gaps();
        // Ready raised long before valid must not cause an early or extra transfer.
        bus.config_out_ready = 1'b1;
        run_cfg("gaps", base_words, 32'h1234_5678, 1'b1, 0, 1'b0);
    endtask

    task automatic test_inc_dec_error();
        words_t w = base_words;
        w[0] = 32'h3;
        run_cfg("incdec", w, 32'h0000_0003, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_fields();
        words_t w = base_words;
        w[6] = 32'h0;
        run_cfg("zero_gran", w, 32'h0000_0006, 1'b0, 0, 1'b0);
        w    = base_words;
        w[5] = 32'h0;
        run_cfg("zero_stride", w, 32'h0000_0005, 1'b1, 0, 1'b0);
    endtask

    task automatic test_high_bits_and_values();
        words_t w;
        w[0] = 32'hFFFF_FFFA;
        w[1] = 32'hFFFF_0000;
        w[2] = 32'h0000_FFFF;
        w[3] = 32'h8000_0001;
        w[4] = 32'h7FFF_FFFE;
        w[5] = 32'h0000_0010;
        w[6] = 32'hFFFF_FFFF;
        run_cfg("highbits", w, 32'hCAFE_F00D, 1'b0, 2, 1'b0);
    endtask

    task automatic test_mid_reset();
        words_t w = base_words;
        w[0] = 32'h6;
        w[1] = 32'h7777_0000;
        w[2] = 32'h99;
        feed(w, 32'hFFFF_FFFF, 1'b0, 3);
        areset = 1'b1;
        tick();
        vectors++;
        if (bus.resp_in_ready !== 1'b0 || bus.config_out_valid !== 1'b0 || bus.config_error !== 1'b0
            || bus.done_out !== 1'b0 || bus.config_out_param !== '0 || bus.config_out_meta !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b err=%b done=%b param=%h meta=%h, required all 0",
                     bus.resp_in_ready, bus.config_out_valid, bus.config_error, bus.done_out,
                     bus.config_out_param, bus.config_out_meta);
        end
        areset = 1'b0;
        tick();
        run_cfg("after_reset", base_words, 32'h0BAD_C0DE, 1'b0, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        words_t w = base_words;
        w[0] = 32'hA;
        w[1] = 32'h2000;
        run_cfg("b2b_a", w, 32'h1, 1'b0, 0, 1'b0);
        run_cfg("b2b_b", base_words, 32'h2, 1'b0, 1, 1'b0);
    endtask

    initial begin
        base_words[0] = 32'h5;
        base_words[1] = 32'h1000;
        base_words[2] = 32'h40;
        base_words[3] = 32'h0;
        base_words[4] = 32'h40;
        base_words[5] = 32'h1;
        base_words[6] = 32'h8;
        test_reset();
        test_basic();
        test_backpressure();
        test_valid_gaps();
        bus.config_out_ready = 1'b0;
        test_inc_dec_error();
        test_zero_fields();
        test_high_bits_and_values();
        test_mid_reset();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
